// File: rtl/core_share_pkg.sv
// Shared types and sizing for the core share scheduler.
// Owner index width comes from ownw() so ports stay consistent.
package core_share_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    DONE,
    ABORT
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_CFGW = 32;
  localparam int DEF_CNTW = 16;

  function automatic int ownw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request strictly after ptr, with wrap.
// Purely combinational; the pointer register lives in the caller.
module rr_arbiter
  import core_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]       req,
  input  logic [ownw(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]       gnt,
  output logic [ownw(NREQ)-1:0] idx,
  output logic                  any
);

  localparam int OW = ownw(NREQ);

  always_comb begin : pick
    logic [OW-1:0] j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = OW'((int'(ptr) + i) % NREQ);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/core_share_sched.sv
// Time-shares one compute core among NREQ requesters:
// round-robin grant, start pulse, done or watchdog abort.
module core_share_sched
  import core_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CFGW = DEF_CFGW,
  parameter int CNTW = DEF_CNTW
) (
  input  logic                  clk,
  input  logic                  xrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CFGW-1:0]  req_cfg,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       err,
  output logic                  core_start,
  output logic                  core_abort,
  output logic [CFGW-1:0]       core_cfg,
  input  logic                  core_done,
  input  logic [CNTW-1:0]       timeout_lim,
  output logic                  busy,
  output logic [ownw(NREQ)-1:0] owner,
  output logic [CNTW-1:0]       cycles
);

  localparam int OW = ownw(NREQ);

  state_t          state_q, state_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   owner_d, gidx;
  logic [NREQ-1:0] gnt, ack_d, err_d;
  logic            gany, start_d, abort_d, busy_d;
  logic [CFGW-1:0] cfg_sel, cfg_d;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc, cycles_d;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req(req),
    .ptr(ptr_q),
    .gnt(gnt),
    .idx(gidx),
    .any(gany)
  );

  always_comb begin
    cfg_sel = '0;
    for (int i = 0; i < NREQ; i++)
      cfg_sel |= req_cfg[i*CFGW +: CFGW] & {CFGW{gnt[i]}};
  end

  // run counter saturates instead of wrapping
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner;
    cfg_d    = core_cfg;
    cnt_d    = cnt_q;
    cycles_d = cycles;
    ack_d    = '0;
    err_d    = '0;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gany) begin
          state_d = START;
          ptr_d   = gidx;
          owner_d = gidx;
          cfg_d   = cfg_sel;
          start_d = 1'b1;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (core_done) begin
          state_d       = DONE;
          cycles_d      = cnt_inc;
          ack_d[owner]  = 1'b1;
        end else if (timeout_lim != '0 &&
                     cnt_inc == timeout_lim) begin
          state_d       = ABORT;
          cycles_d      = cnt_inc;
          err_d[owner]  = 1'b1;
          abort_d       = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q    <= IDLE;
      ptr_q      <= OW'(NREQ - 1);
      owner      <= '0;
      core_cfg   <= '0;
      cnt_q      <= '0;
      cycles     <= '0;
      ack        <= '0;
      err        <= '0;
      core_start <= 1'b0;
      core_abort <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner      <= owner_d;
      core_cfg   <= cfg_d;
      cnt_q      <= cnt_d;
      cycles     <= cycles_d;
      ack        <= ack_d;
      err        <= err_d;
      core_start <= start_d;
      core_abort <= abort_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_core_share_sched.sv
// Scoreboard bench for core_share_sched: stimulus queues expected
// starts/responses, a negedge monitor pops and compares them.
module tb_core_share_sched;

  localparam int NREQ = 4;
  localparam int CFGW = 32;
  localparam int CNTW = 8;

  typedef struct {
    int          own;
    logic [31:0] cfg;
  } st_t;

  typedef struct {
    int own;
    bit to;
    int cyc;
  } rs_t;

  logic                 clk;
  logic                 xrst;
  logic [NREQ-1:0]      req;
  logic [NREQ*CFGW-1:0] req_cfg;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      err;
  logic                 core_start;
  logic                 core_abort;
  logic [CFGW-1:0]      core_cfg;
  logic                 core_done;
  logic [CNTW-1:0]      timeout_lim;
  logic                 busy;
  logic [1:0]           owner;
  logic [CNTW-1:0]      cycles;

  int  checks = 0;
  int  errors = 0;
  st_t stq[$];
  rs_t rsq[$];
  st_t es;
  rs_t er;

  core_share_sched #(
    .NREQ(NREQ),
    .CFGW(CFGW),
    .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .xrst(xrst),
    .req(req),
    .req_cfg(req_cfg),
    .ack(ack),
    .err(err),
    .core_start(core_start),
    .core_abort(core_abort),
    .core_cfg(core_cfg),
    .core_done(core_done),
    .timeout_lim(timeout_lim),
    .busy(busy),
    .owner(owner),
    .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (xrst === 1'b1) begin
      if (core_start) begin
        if (stq.size() == 0) begin
          check("start_unexpected", 64'(core_start), 64'd0);
        end else begin
          es = stq.pop_front();
          check("start_owner", 64'(owner), 64'(es.own));
          check("start_cfg", 64'(core_cfg), 64'(es.cfg));
          check("start_busy", 64'(busy), 64'd1);
        end
      end
      if (|ack || |err || core_abort) begin
        if (rsq.size() == 0) begin
          check("resp_unexpected", 64'({err, ack, core_abort}), 64'd0);
        end else begin
          er = rsq.pop_front();
          check("resp_ack", 64'(ack),
                er.to ? 64'd0 : 64'(4'b0001 << er.own));
          check("resp_err", 64'(err),
                er.to ? 64'(4'b0001 << er.own) : 64'd0);
          check("resp_abort", 64'(core_abort), 64'(er.to));
          check("resp_cycles", 64'(cycles), 64'(er.cyc));
          check("resp_owner", 64'(owner), 64'(er.own));
        end
      end
    end
  end

  task automatic serve(input int own, input int nrun, input bit to,
                       input int cyc, input int lat_exp,
                       input logic [3:0] drop, input bit early_drop);
    int  lat;
    st_t s;
    rs_t r;
    s.own = own;
    s.cfg = 32'hC0DE_1000 + own;
    stq.push_back(s);
    r.own = own;
    r.to  = to;
    r.cyc = cyc;
    rsq.push_back(r);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("start_latency", 64'(lat), 64'(lat_exp));
    if (early_drop) req[own] = 1'b0;
    if (to) begin
      repeat (nrun + 1) @(negedge clk);
    end else begin
      repeat (nrun) @(negedge clk);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
    end
    check("busy_at_end", 64'(busy), 64'd1);
    req = req & ~drop;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_start"}, 64'(core_start), 64'd0);
    check({tag, "_abort"}, 64'(core_abort), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_cfg"}, 64'(core_cfg), 64'd0);
    check({tag, "_cycles"}, 64'(cycles), 64'd0);
    check({tag, "_owner"}, 64'(owner), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat;
    st_t s;
    xrst        = 1'b0;
    req         = '0;
    core_done   = 1'b0;
    timeout_lim = '0;
    for (int i = 0; i < NREQ; i++)
      req_cfg[i*CFGW +: CFGW] = 32'hC0DE_1000 + i;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    xrst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // all four held: grant order 0,1,2,3,0
    req = 4'b1111;
    serve(0, 3, 0, 3, 1, 4'b0000, 0);
    serve(1, 3, 0, 3, 2, 4'b0000, 0);
    serve(2, 3, 0, 3, 2, 4'b0000, 0);
    serve(3, 3, 0, 3, 2, 4'b0000, 0);
    serve(0, 3, 0, 3, 2, 4'b1111, 0);
    repeat (3) @(negedge clk);

    // single requester 2, done after 5 run cycles
    req = 4'b0100;
    serve(2, 5, 0, 5, 1, 4'b0100, 0);
    @(negedge clk);
    check("hold_owner", 64'(owner), 64'd2);
    check("hold_cycles", 64'(cycles), 64'd5);
    check("hold_cfg", 64'(core_cfg), 64'hC0DE_1002);
    repeat (2) @(negedge clk);

    // watchdog abort at 8 run cycles
    timeout_lim = 8'd8;
    req = 4'b1000;
    serve(3, 8, 1, 8, 1, 4'b1000, 0);
    @(negedge clk);
    check("abort_busy_fall", 64'(busy), 64'd0);
    check("abort_pulse_end", 64'(core_abort), 64'd0);
    repeat (2) @(negedge clk);

    // done on the same edge as the timeout: done wins
    req = 4'b0001;
    serve(0, 8, 0, 8, 1, 4'b0001, 0);
    repeat (2) @(negedge clk);

    // saturating counter, req dropped right after grant
    timeout_lim = 8'd0;
    req = 4'b0010;
    serve(1, 300, 0, 255, 1, 4'b0000, 1);
    repeat (2) @(negedge clk);

    // reset in the middle of a run
    s.own = 1;
    s.cfg = 32'hC0DE_1001;
    stq.push_back(s);
    req = 4'b0010;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("mid_start_latency", 64'(lat), 64'd1);
    repeat (3) @(negedge clk);
    xrst = 1'b0;
    #1;
    check_all_zero("midrst");
    req = 4'b0011;
    @(negedge clk);
    xrst = 1'b1;
    serve(0, 2, 0, 2, 1, 4'b0001, 0);
    serve(1, 1, 0, 1, 2, 4'b0010, 0);
    repeat (4) @(negedge clk);

    check("start_queue_empty", 64'(stq.size()), 64'd0);
    check("resp_queue_empty", 64'(rsq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
